// File: rtl/bf2_sdf_stage.sv
// Radix-2 single-path delay-feedback butterfly stage. The DELAY-deep delay line
// lives outside; this block drives its input and consumes its output.
module bf2_sdf_stage #(
   parameter int W     = 29,
   parameter int DELAY = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   input  logic [W-1:0] din_r,
   input  logic [W-1:0] din_i,
   input  logic [W-1:0] fifo_dor,
   input  logic [W-1:0] fifo_doi,
   output logic [W-1:0] to_fifo_r,
   output logic [W-1:0] to_fifo_i,
   output logic [W-1:0] dout_r,
   output logic [W-1:0] dout_i,
   output logic         out_valid,
   output logic         sync_err,
   output logic         ovf,
   output logic [1:0]   fsm_state
);

   // Stream handshake: in_valid qualifies din in the cycle it is high and
   // out_valid qualifies dout; there is no ready/backpressure in either direction.
   localparam int CW = $clog2(2 * DELAY);
   localparam int DW = $clog2(DELAY);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [DW-1:0] dcnt;
   logic          primed;

   logic [W:0]    sum_r, sum_i, dif_r, dif_i;
   logic          wrap;
   logic          phase_b;

   assign sum_r = {fifo_dor[W-1], fifo_dor} + {din_r[W-1], din_r};
   assign sum_i = {fifo_doi[W-1], fifo_doi} + {din_i[W-1], din_i};
   assign dif_r = {fifo_dor[W-1], fifo_dor} - {din_r[W-1], din_r};
   assign dif_i = {fifo_doi[W-1], fifo_doi} - {din_i[W-1], din_i};

   assign wrap = (sum_r[W] ^ sum_r[W-1]) | (sum_i[W] ^ sum_i[W-1]) |
                 (dif_r[W] ^ dif_r[W-1]) | (dif_i[W] ^ dif_i[W-1]);

   // cnt >= DELAY is just the counter MSB because 2*DELAY is a power of two.
   assign phase_b   = (state == RUN) && cnt[CW-1];
   assign fsm_state = state;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         cnt       <= '0;
         dcnt      <= '0;
         primed    <= 1'b0;
         to_fifo_r <= '0;
         to_fifo_i <= '0;
         dout_r    <= '0;
         dout_i    <= '0;
         out_valid <= 1'b0;
         sync_err  <= 1'b0;
         ovf       <= 1'b0;
      end else if (in_valid) begin
         // A sample arriving in IDLE or DRAIN is phase A of a fresh group (cnt is 0).
         if (phase_b) begin
            dout_r    <= sum_r[W-1:0];
            dout_i    <= sum_i[W-1:0];
            to_fifo_r <= dif_r[W-1:0];
            to_fifo_i <= dif_i[W-1:0];
            out_valid <= 1'b1;
            if (wrap) ovf <= 1'b1;
         end else begin
            to_fifo_r <= din_r;
            to_fifo_i <= din_i;
            out_valid <= primed;
            if (primed) begin
               dout_r <= fifo_dor;
               dout_i <= fifo_doi;
            end
         end
         cnt   <= cnt + CW'(1);
         state <= RUN;
         if (cnt == CW'(2 * DELAY - 1)) primed <= 1'b1;
      end else begin
         to_fifo_r <= '0;
         to_fifo_i <= '0;
         case (state)
            RUN: begin
               if (cnt != '0) begin
                  sync_err  <= 1'b1;
                  cnt       <= '0;
                  primed    <= 1'b0;
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end else if (primed) begin
                  // This gap cycle already emits the first of the DELAY drain outputs.
                  dout_r    <= fifo_dor;
                  dout_i    <= fifo_doi;
                  out_valid <= 1'b1;
                  dcnt      <= DW'(1);
                  state     <= DRAIN;
               end else begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            DRAIN: begin
               dout_r    <= fifo_dor;
               dout_i    <= fifo_doi;
               out_valid <= 1'b1;
               if (dcnt == DW'(DELAY - 1)) begin
                  dcnt   <= '0;
                  primed <= 1'b0;
                  state  <= IDLE;
               end else begin
                  dcnt <= dcnt + DW'(1);
               end
            end
            default: begin
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bf2_sdf_stage.sv
// Directed bench for bf2_sdf_stage with an ideal delay line; each task drives
// one scenario and checks hand-computed outputs inline.
module tb_bf2_sdf_stage;

   localparam int W     = 29;
   localparam int DELAY = 16;
   localparam logic [W-1:0] M16 = 29'h1FFFFFF0;
   localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         in_valid = 1'b0;
   logic [W-1:0] din_r = '0, din_i = '0;
   logic [W-1:0] fifo_dor, fifo_doi;
   logic [W-1:0] to_fifo_r, to_fifo_i, dout_r, dout_i;
   logic         out_valid, sync_err, ovf;
   logic [1:0]   fsm_state;

   int errors = 0;
   int checks = 0;

   bf2_sdf_stage #(.W(W), .DELAY(DELAY)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid),
      .din_r(din_r), .din_i(din_i), .fifo_dor(fifo_dor), .fifo_doi(fifo_doi),
      .to_fifo_r(to_fifo_r), .to_fifo_i(to_fifo_i), .dout_r(dout_r), .dout_i(dout_i),
      .out_valid(out_valid), .sync_err(sync_err), .ovf(ovf), .fsm_state(fsm_state)
   );

   always #5 clk = ~clk;

   // The registered to_fifo is the first of the DELAY stages, so DELAY-1 more follow.
   logic [W-1:0] fr [DELAY-1];
   logic [W-1:0] fi [DELAY-1];
   always @(posedge clk) begin
      fr[0] <= to_fifo_r;
      fi[0] <= to_fifo_i;
      for (int k = 1; k < DELAY - 1; k++) begin
         fr[k] <= fr[k-1];
         fi[k] <= fi[k-1];
      end
   end
   assign fifo_dor = fr[DELAY-2];
   assign fifo_doi = fi[DELAY-2];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   task automatic step(input logic v, input logic [W-1:0] r, input logic [W-1:0] i);
      @(negedge clk);
      in_valid = v;
      din_r    = r;
      din_i    = i;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      in_valid = 1'b1;
      din_r    = 29'h0000_1234;
      din_i    = 29'h0000_0042;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({out_valid, sync_err, ovf, dout_r, dout_i, to_fifo_r, to_fifo_i, fsm_state} !== '0) begin
         errors++;
         $display("FAIL reset_state: valid=%b serr=%b ovf=%b dout=%h/%h to_fifo=%h/%h st=%0d, all required 0",
                  out_valid, sync_err, ovf, dout_r, dout_i, to_fifo_r, to_fifo_i, fsm_state);
      end
      @(negedge clk);
      in_valid = 1'b0;
      rst      = 1'b1;
      step(1'b0, '0, '0);
      checks++;
      if (out_valid !== 1'b0 || fsm_state !== S_IDLE) begin
         errors++;
         $display("FAIL reset_release: valid=%b st=%0d required 0/%0d", out_valid, fsm_state, S_IDLE);
      end
   endtask

   task automatic test_single_group();
      for (int n = 0; n < 32; n++) begin
         step(1'b1, W'(n + 1), '0);
         checks++;
         if (n < 16) begin
            if (out_valid !== 1'b0 || dout_r !== '0 || to_fifo_r !== W'(n + 1)) begin
               errors++;
               $display("FAIL single_phase_a n=%0d: valid=%b dout_r=%h to_fifo_r=%h required 0/0/%h",
                        n, out_valid, dout_r, to_fifo_r, W'(n + 1));
            end
         end else if (out_valid !== 1'b1 || dout_r !== W'(2 * n - 14) || dout_i !== '0 || to_fifo_r !== M16) begin
            errors++;
            $display("FAIL single_phase_b n=%0d: valid=%b dout=%h/%h to_fifo_r=%h required 1/%h/0/%h",
                     n, out_valid, dout_r, dout_i, to_fifo_r, W'(2 * n - 14), M16);
         end
      end
      for (int k = 0; k < 16; k++) begin
         step(1'b0, '0, '0);
         checks++;
         if (out_valid !== 1'b1 || dout_r !== M16 || dout_i !== '0 || to_fifo_r !== '0 ||
             fsm_state !== ((k == 15) ? S_IDLE : S_DRAIN)) begin
            errors++;
            $display("FAIL single_drain k=%0d: valid=%b dout=%h/%h to_fifo_r=%h st=%0d required 1/%h/0/0",
                     k, out_valid, dout_r, dout_i, to_fifo_r, fsm_state, M16);
         end
      end
      step(1'b0, '0, '0);
      checks++;
      if (out_valid !== 1'b0 || dout_r !== M16 || fsm_state !== S_IDLE || sync_err !== 1'b0 || ovf !== 1'b0) begin
         errors++;
         $display("FAIL single_idle: valid=%b dout_r=%h st=%0d serr=%b ovf=%b required 0/%h/0/0/0",
                  out_valid, dout_r, fsm_state, sync_err, ovf, M16);
      end
   endtask

   task automatic test_back_to_back();
      int vcount = 0;
      for (int n = 0; n < 64; n++) begin
         int m = n % 32;
         logic         e_v;
         logic [W-1:0] e_r, e_i;
         if (n < 32) step(1'b1, W'(m + 1), W'(3 * m));
         else        step(1'b1, W'(100 + m), '0);
         if (out_valid === 1'b1) vcount++;
         e_v = 1'b1;
         e_r = '0;
         e_i = '0;
         if (n < 16) begin
            e_v = 1'b0;
         end else if (n < 32) begin
            e_r = W'(2 * m - 14);
            e_i = W'(6 * m - 48);
         end else if (n < 48) begin
            e_r = M16;
            e_i = W'(-48);
         end else begin
            e_r = W'(2 * m + 184);
         end
         checks++;
         if (out_valid !== e_v || (e_v && (dout_r !== e_r || dout_i !== e_i))) begin
            errors++;
            $display("FAIL b2b n=%0d: valid=%b dout=%h/%h required %b/%h/%h",
                     n, out_valid, dout_r, dout_i, e_v, e_r, e_i);
         end
      end
      checks++;
      if (vcount !== 48) begin
         errors++;
         $display("FAIL b2b_valid_run: valid cycles=%0d required 48", vcount);
      end
      for (int k = 0; k < 17; k++) begin
         step(1'b0, '0, '0);
         checks++;
         if (out_valid !== (k < 16) || (k < 16 && (dout_r !== M16 || dout_i !== '0))) begin
            errors++;
            $display("FAIL b2b_drain k=%0d: valid=%b dout=%h/%h required %b/%h/0",
                     k, out_valid, dout_r, dout_i, (k < 16), M16);
         end
      end
   endtask

   task automatic test_sync_err();
      for (int n = 0; n < 10; n++) step(1'b1, W'(n + 1), '0);
      step(1'b0, '0, '0);
      checks++;
      if (sync_err !== 1'b1 || out_valid !== 1'b0 || fsm_state !== S_IDLE || to_fifo_r !== '0) begin
         errors++;
         $display("FAIL sync_err_set: serr=%b valid=%b st=%0d to_fifo_r=%h required 1/0/0/0",
                  sync_err, out_valid, fsm_state, to_fifo_r);
      end
      for (int n = 0; n < 32; n++) begin
         step(1'b1, W'(5 * n + 2), W'(-n));
         checks++;
         if (n < 16) begin
            if (out_valid !== 1'b0) begin
               errors++;
               $display("FAIL sync_regroup_a n=%0d: valid=%b required 0", n, out_valid);
            end
         end else if (out_valid !== 1'b1 || dout_r !== W'(10 * n - 76) || dout_i !== W'(16 - 2 * n)) begin
            errors++;
            $display("FAIL sync_regroup_b n=%0d: valid=%b dout=%h/%h required 1/%h/%h",
                     n, out_valid, dout_r, dout_i, W'(10 * n - 76), W'(16 - 2 * n));
         end
      end
      for (int k = 0; k < 17; k++) begin
         step(1'b0, '0, '0);
         checks++;
         if (out_valid !== (k < 16) || (k < 16 && (dout_r !== W'(-80) || dout_i !== W'(16)))) begin
            errors++;
            $display("FAIL sync_drain k=%0d: valid=%b dout=%h/%h required %b/%h/%h",
                     k, out_valid, dout_r, dout_i, (k < 16), W'(-80), W'(16));
         end
      end
      checks++;
      if (sync_err !== 1'b1) begin
         errors++;
         $display("FAIL sync_err_sticky: serr=%b required 1", sync_err);
      end
   endtask

   task automatic test_drain_abort();
      for (int n = 0; n < 32; n++) step(1'b1, W'(n + 1), '0);
      for (int k = 0; k < 5; k++) begin
         step(1'b0, '0, '0);
         checks++;
         if (out_valid !== 1'b1 || dout_r !== M16 || fsm_state !== S_DRAIN) begin
            errors++;
            $display("FAIL abort_drain k=%0d: valid=%b dout_r=%h st=%0d required 1/%h/%0d",
                     k, out_valid, dout_r, fsm_state, M16, S_DRAIN);
         end
      end
      for (int n = 0; n < 32; n++) begin
         logic [W-1:0] e_r;
         step(1'b1, W'(200 + n), '0);
         if (n < 11)      e_r = M16;
         else if (n < 16) e_r = '0;
         else             e_r = W'(2 * n + 384);
         checks++;
         if (out_valid !== 1'b1 || dout_r !== e_r || dout_i !== '0 || fsm_state !== S_RUN) begin
            errors++;
            $display("FAIL abort_group n=%0d: valid=%b dout=%h/%h st=%0d required 1/%h/0/%0d",
                     n, out_valid, dout_r, dout_i, fsm_state, e_r, S_RUN);
         end
      end
      for (int k = 0; k < 17; k++) begin
         step(1'b0, '0, '0);
         checks++;
         if (out_valid !== (k < 16) || (k < 16 && dout_r !== M16)) begin
            errors++;
            $display("FAIL abort_final_drain k=%0d: valid=%b dout_r=%h required %b/%h",
                     k, out_valid, dout_r, (k < 16), M16);
         end
      end
   endtask

   task automatic test_overflow();
      checks++;
      if (ovf !== 1'b0) begin
         errors++;
         $display("FAIL ovf_clear_before: ovf=%b required 0", ovf);
      end
      for (int n = 0; n < 32; n++) begin
         step(1'b1, (n == 0 || n == 16) ? 29'h0FFF_FFFF : 29'h1, '0);
         if (n == 15) begin
            checks++;
            if (ovf !== 1'b0) begin
               errors++;
               $display("FAIL ovf_early: ovf=%b required 0", ovf);
            end
         end else if (n == 16) begin
            checks++;
            if (dout_r !== 29'h1FFF_FFFE || ovf !== 1'b1 || to_fifo_r !== '0) begin
               errors++;
               $display("FAIL ovf_wrap: dout_r=%h ovf=%b to_fifo_r=%h required 1FFFFFFE/1/0",
                        dout_r, ovf, to_fifo_r);
            end
         end else if (n > 16) begin
            checks++;
            if (dout_r !== W'(2) || ovf !== 1'b1) begin
               errors++;
               $display("FAIL ovf_hold n=%0d: dout_r=%h ovf=%b required 2/1", n, dout_r, ovf);
            end
         end
      end
      for (int k = 0; k < 17; k++) begin
         step(1'b0, '0, '0);
         checks++;
         if (out_valid !== (k < 16) || (k < 16 && dout_r !== '0) || ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_drain k=%0d: valid=%b dout_r=%h ovf=%b required %b/0/1",
                     k, out_valid, dout_r, ovf, (k < 16));
         end
      end
   endtask

   task automatic test_reset_mid_drain();
      for (int n = 0; n < 32; n++) step(1'b1, W'(n + 1), '0);
      for (int k = 0; k < 3; k++) step(1'b0, '0, '0);
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if ({out_valid, sync_err, ovf, dout_r, dout_i, to_fifo_r, to_fifo_i, fsm_state} !== '0) begin
         errors++;
         $display("FAIL async_reset: valid=%b serr=%b ovf=%b dout=%h/%h to_fifo=%h/%h st=%0d, all required 0",
                  out_valid, sync_err, ovf, dout_r, dout_i, to_fifo_r, to_fifo_i, fsm_state);
      end
      @(negedge clk);
      #2;
      rst = 1'b1;
      for (int n = 0; n < 32; n++) begin
         step(1'b1, W'(7 * n + 3), '0);
         checks++;
         if (n < 16) begin
            if (out_valid !== 1'b0 || dout_r !== '0) begin
               errors++;
               $display("FAIL post_reset_a n=%0d: valid=%b dout_r=%h required 0/0", n, out_valid, dout_r);
            end
         end else if (out_valid !== 1'b1 || dout_r !== W'(14 * n - 106)) begin
            errors++;
            $display("FAIL post_reset_b n=%0d: valid=%b dout_r=%h required 1/%h",
                     n, out_valid, dout_r, W'(14 * n - 106));
         end
      end
      for (int k = 0; k < 17; k++) begin
         step(1'b0, '0, '0);
         checks++;
         if (out_valid !== (k < 16) || (k < 16 && dout_r !== W'(-112))) begin
            errors++;
            $display("FAIL post_reset_drain k=%0d: valid=%b dout_r=%h required %b/%h",
                     k, out_valid, dout_r, (k < 16), W'(-112));
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_group();
      test_back_to_back();
      test_sync_err();
      test_drain_abort();
      test_overflow();
      test_reset_mid_drain();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
